vending_input_conditioner: RTL and testbench
============================================

VENDING_INPUT_CONDITIONER -- requirements
Module: vending_input_conditioner

Interface
REQ-001 Parameter DEB_CNT, default 50000, is the number of consecutive stable cycles required to accept a level change; the legal range is 2..65535.
REQ-002 Parameter CNT_W, default 16, is the width of each debounce counter.
REQ-003 clk  input  1  single system clock; all logic is on the rising edge.
REQ-004 rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-005 i_btn_coin  input  1  raw coin-slot switch; asynchronous and bouncy.
REQ-006 i_btn_coffee  input  1  raw coffee button; asynchronous and bouncy.
REQ-007 i_btn_sprite  input  1  raw sprite button; asynchronous and bouncy.
REQ-008 o_coin  output  1  one-cycle coin pulse that feeds the vending FSM coin input.
REQ-009 o_coffee  output  1  one-cycle coffee-request pulse that feeds the vending FSM coffee input.
REQ-010 o_sprite  output  1  one-cycle sprite-request pulse that feeds the vending FSM sprite input.
REQ-011 o_busy  output  1  high while any accepted press is pending and not yet issued.

Function
REQ-012 Each raw input SHALL pass through its own 2-flop synchronizer (sync1, sync2); both flops reset to 0.
REQ-013 Each channel SHALL hold a debounced level "stable" (reset 0) and a CNT_W-bit counter (reset 0).
REQ-014 On a cycle where sync2 == stable, the channel counter SHALL clear to 0.
REQ-015 On a cycle where sync2 != stable and counter < DEB_CNT-1, the counter SHALL increment by 1.
REQ-016 On a cycle where sync2 != stable and counter == DEB_CNT-1, stable SHALL take sync2 and the counter SHALL clear to 0.
REQ-017 The debounce counter SHALL never wrap; any mismatch run shorter than DEB_CNT cycles SHALL be discarded without changing stable.
REQ-018 A 0->1 transition of stable SHALL set that channel's pending flag; a 1->0 transition SHALL produce nothing.
REQ-019 A rising transition on a channel whose pending flag is already set SHALL leave the flag set, with no double count and no queue depth beyond 1.
REQ-020 Arbiter: on each cycle with any pending flag set, the block SHALL issue exactly one registered pulse in the next cycle, in fixed priority o_coin > o_coffee > o_sprite.
REQ-021 The arbiter SHALL clear the pending flag of the issued channel; lower-priority flags SHALL remain set and be issued on subsequent cycles.
REQ-022 At most one of o_coin/o_coffee/o_sprite SHALL be high in any cycle (one-hot or zero).
REQ-023 Each output pulse SHALL be exactly 1 cycle wide, with at least 1 low cycle between consecutive pulses on the same output.
REQ-024 A pending flag being set and a different flag being cleared in the same cycle SHALL both take effect.
REQ-025 If a flag is set in the same cycle it would be issued, set SHALL win for a newly-rising channel and clear SHALL win for the issued channel.
REQ-026 Latency SHALL be exactly DEB_CNT+3 cycles for an isolated clean press: from the first rising clk edge sampling raw=1 to the cycle in which the output is high.
REQ-027 o_busy SHALL be the registered OR of all pending flags.
REQ-028 A held button SHALL produce exactly one pulse; a new pulse requires a debounced release followed by a debounced press.
REQ-029 All outputs SHALL be driven from flops, with no combinational path from inputs to outputs.

Reset
REQ-030 While rst=1 at a clk edge, the block SHALL set all synchronizer flops, stable levels, counters, pending flags, o_coin, o_coffee, o_sprite and o_busy to 0.
REQ-031 Reset asserted mid-debounce or with presses pending SHALL discard them; no pulse SHALL appear due to pre-reset activity.
REQ-032 A button held high through reset release SHALL be treated as a new press and produce one pulse DEB_CNT+3 cycles after release.

Verification (DEB_CNT=4)
REQ-033 Clean coin press held 20 cycles -> o_coin high for exactly 1 cycle, 7 cycles after first sampled high; o_coffee=o_sprite=0.
REQ-034 Coffee input toggling every 2 cycles for 30 cycles, then held high -> no pulse during toggling; exactly one o_coffee pulse 7 cycles after the final rise.
REQ-035 All three buttons rise on the same edge -> o_coin in cycle N, o_coffee in N+1, o_sprite in N+2; o_busy high in N-1..N+1 and low in N+2.
REQ-036 Sprite press, with rst pulsed 1 cycle while the debounce count = 2, then button released -> no o_sprite pulse and all outputs 0.
REQ-037 Two coin presses separated by a 10-cycle debounced release -> exactly two o_coin pulses, 1 cycle wide each, 7 cycles after each rise.
REQ-038 Coin held high through reset release -> one o_coin pulse 7 cycles after rst falls, with no further pulses while held.

Source files
------------

// File: rtl/vending_input_conditioner.sv
// Conditions three raw vending-machine switches into single-cycle request pulses:
// 2-flop synchronizer, saturating debounce, rise capture, fixed-priority issue.
module vending_input_conditioner #(
  parameter int DEB_CNT = 50000,
  parameter int CNT_W   = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn_coin,
  input  logic i_btn_coffee,
  input  logic i_btn_sprite,
  output logic o_coin,
  output logic o_coffee,
  output logic o_sprite,
  output logic o_busy
);

  localparam int NCH = 3;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CNT - 1);

  // Channel order is also issue priority: bit 0 (coin) wins.
  logic [NCH-1:0] raw_vec;
  logic [NCH-1:0] rise_vec;

  assign raw_vec = {i_btn_sprite, i_btn_coffee, i_btn_coin};

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      logic             sync1_reg;
      logic             sync2_reg;
      logic             stable_reg;
      logic             stable_next;
      logic             stable_d_reg;
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;

      // A level is accepted only after DEB_CNT consecutive disagreeing cycles;
      // any agreement restarts the count, so short bounces are dropped.
      always_comb begin
        stable_next = stable_reg;
        cnt_next    = '0;
        if (sync2_reg != stable_reg) begin
          if (cnt_reg >= CNT_MAX) begin
            stable_next = sync2_reg;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          sync1_reg    <= 1'b0;
          sync2_reg    <= 1'b0;
          stable_reg   <= 1'b0;
          stable_d_reg <= 1'b0;
          cnt_reg      <= '0;
        end else begin
          sync1_reg    <= raw_vec[gi];
          sync2_reg    <= sync1_reg;
          stable_reg   <= stable_next;
          stable_d_reg <= stable_reg;
          cnt_reg      <= cnt_next;
        end
      end

      assign rise_vec[gi] = stable_reg & ~stable_d_reg;
    end
  endgenerate

  logic [NCH-1:0] pend_reg;
  logic [NCH-1:0] pend_next;
  logic [NCH-1:0] grant;

  // Issue the highest-priority pending request; new rises merge into the
  // flags, but the channel being issued this cycle is always cleared.
  always_comb begin
    grant = '0;
    if (pend_reg[0]) begin
      grant = 3'b001;
    end else if (pend_reg[1]) begin
      grant = 3'b010;
    end else if (pend_reg[2]) begin
      grant = 3'b100;
    end
    pend_next = (pend_reg | rise_vec) & ~grant;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_reg <= '0;
      o_coin   <= 1'b0;
      o_coffee <= 1'b0;
      o_sprite <= 1'b0;
      o_busy   <= 1'b0;
    end else begin
      pend_reg <= pend_next;
      o_coin   <= grant[0];
      o_coffee <= grant[1];
      o_sprite <= grant[2];
      o_busy   <= |pend_next;
    end
  end

endmodule

// File: tb/tb_vending_input_conditioner.sv
// Directed bench for vending_input_conditioner with DEB_CNT=4: a cycle model
// checked every cycle plus literal latency/count expectations per scenario.
module tb_vending_input_conditioner;

  localparam int DEB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic b_coin = 1'b0;
  logic b_coffee = 1'b0;
  logic b_sprite = 1'b0;
  logic o_coin, o_coffee, o_sprite, o_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int coin_t[$];
  int coffee_t[$];
  int sprite_t[$];

  always #5 clk = ~clk;

  vending_input_conditioner #(.DEB_CNT(DEB), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_btn_coin   (b_coin),
    .i_btn_coffee (b_coffee),
    .i_btn_sprite (b_sprite),
    .o_coin       (o_coin),
    .o_coffee     (o_coffee),
    .o_sprite     (o_sprite),
    .o_busy       (o_busy)
  );

  // Model: input delayed two cycles, accepted after DEB disagreeing cycles,
  // rise captured a cycle later, lowest-index pending request issued.
  logic [2:0] m_d1 = '0, m_d2 = '0, m_stab = '0, m_rise = '0, m_pend = '0, m_out = '0;
  logic       m_busy = 1'b0;
  int         m_run[3] = '{0, 0, 0};

  always @(posedge clk) begin
    logic [2:0] raw;
    logic [2:0] g;
    cyc++;
    raw = {b_sprite, b_coffee, b_coin};
    if (rst) begin
      m_d1 = '0; m_d2 = '0; m_stab = '0; m_rise = '0; m_pend = '0; m_out = '0;
      m_busy = 1'b0;
      for (int ch = 0; ch < 3; ch++) m_run[ch] = 0;
    end else begin
      g      = m_pend & (~m_pend + 3'd1);
      m_out  = g;
      m_pend = (m_pend | m_rise) & ~g;
      m_busy = |m_pend;
      for (int ch = 0; ch < 3; ch++) begin
        m_rise[ch] = 1'b0;
        if (m_d2[ch] == m_stab[ch]) begin
          m_run[ch] = 0;
        end else begin
          m_run[ch]++;
          if (m_run[ch] == DEB) begin
            m_stab[ch] = m_d2[ch];
            m_run[ch]  = 0;
            m_rise[ch] = m_d2[ch];
          end
        end
      end
      m_d2 = m_d1;
      m_d1 = raw;
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      checks++;
      if ({o_sprite, o_coffee, o_coin} !== m_out || o_busy !== m_busy) begin
        errors++;
        $display("FAIL model cyc=%0d got out=%b busy=%b want out=%b busy=%b",
                 cyc, {o_sprite, o_coffee, o_coin}, o_busy, m_out, m_busy);
      end
      checks++;
      if (!$onehot0({o_sprite, o_coffee, o_coin})) begin
        errors++;
        $display("FAIL onehot cyc=%0d got out=%b want at most one high",
                 cyc, {o_sprite, o_coffee, o_coin});
      end
      if (o_coin === 1'b1)   coin_t.push_back(cyc);
      if (o_coffee === 1'b1) coffee_t.push_back(cyc);
      if (o_sprite === 1'b1) sprite_t.push_back(cyc);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int lat_of(input int q[$], input int idx, input int c0);
    if (q.size() > idx) return q[idx] - c0;
    return -1;
  endfunction

  int n0, nc0, ns0, c0, c1;

  initial begin
    wait_n(3);
    chk("reset_outputs", int'({o_sprite, o_coffee, o_coin, o_busy}), 0);
    rst = 1'b0;
    wait_n(3);

    // Clean coin press held 20 cycles
    n0 = coin_t.size(); nc0 = coffee_t.size(); ns0 = sprite_t.size();
    b_coin = 1'b1; c0 = cyc + 1;
    wait_n(20);
    b_coin = 1'b0;
    wait_n(12);
    chk("t1_coin_count", coin_t.size() - n0, 1);
    chk("t1_coin_latency", lat_of(coin_t, n0, c0), 7);
    chk("t1_other_pulses", (coffee_t.size() - nc0) + (sprite_t.size() - ns0), 0);

    // Coffee bouncing every 2 cycles, then held
    nc0 = coffee_t.size();
    for (int i = 0; i < 15; i++) begin
      b_coffee = (i % 2 == 0);
      if (b_coffee) c0 = cyc + 1;
      wait_n(2);
    end
    chk("t2_no_pulse_while_bouncing", coffee_t.size() - nc0, 0);
    wait_n(15);
    b_coffee = 1'b0;
    wait_n(12);
    chk("t2_coffee_count", coffee_t.size() - nc0, 1);
    chk("t2_coffee_latency", lat_of(coffee_t, nc0, c0), 7);

    // All three rise together
    b_coin = 1'b1; b_coffee = 1'b1; b_sprite = 1'b1; c0 = cyc + 1;
    wait_n(6);
    chk("t3_busy_Nm2", int'(o_busy), 0);
    wait_n(1);
    chk("t3_Nm1_out_busy", int'({o_sprite, o_coffee, o_coin, o_busy}), 4'b0001);
    wait_n(1);
    chk("t3_N_out_busy", int'({o_sprite, o_coffee, o_coin, o_busy}), 4'b0011);
    wait_n(1);
    chk("t3_Np1_out_busy", int'({o_sprite, o_coffee, o_coin, o_busy}), 4'b0101);
    wait_n(1);
    chk("t3_Np2_out_busy", int'({o_sprite, o_coffee, o_coin, o_busy}), 4'b1000);
    wait_n(10);
    b_coin = 1'b0; b_coffee = 1'b0; b_sprite = 1'b0;
    wait_n(12);

    // Sprite press cut by reset mid-debounce
    ns0 = sprite_t.size();
    b_sprite = 1'b1; c0 = cyc + 1;
    wait_n(4);
    rst = 1'b1; b_sprite = 1'b0;
    wait_n(1);
    rst = 1'b0;
    wait_n(15);
    chk("t4_sprite_count", sprite_t.size() - ns0, 0);
    chk("t4_outputs_idle", int'({o_sprite, o_coffee, o_coin, o_busy}), 0);

    // Two coin presses separated by a debounced release
    n0 = coin_t.size();
    b_coin = 1'b1; c0 = cyc + 1;
    wait_n(8);
    b_coin = 1'b0;
    wait_n(10);
    b_coin = 1'b1; c1 = cyc + 1;
    wait_n(8);
    b_coin = 1'b0;
    wait_n(12);
    chk("t5_coin_count", coin_t.size() - n0, 2);
    chk("t5_first_latency", lat_of(coin_t, n0, c0), 7);
    chk("t5_second_latency", lat_of(coin_t, n0 + 1, c1), 7);

    // Coin held through reset release
    rst = 1'b1; b_coin = 1'b1;
    wait_n(2);
    n0 = coin_t.size();
    rst = 1'b0; c0 = cyc + 1;
    wait_n(25);
    chk("t6_coin_count_held", coin_t.size() - n0, 1);
    chk("t6_coin_latency", lat_of(coin_t, n0, c0), 7);
    b_coin = 1'b0;
    wait_n(12);
    chk("t6_coin_count_final", coin_t.size() - n0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
